// File: rtl/alu_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : alu_seq_core
// Description : Registered ALU core with a valid/ready handshake on both
//               sides. Single-cycle ADD/SUB/CMP/AND/OR/XOR and a multi-cycle
//               shift-add unsigned multiply. Results and flags are held in
//               output registers until the consumer accepts them.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_seq_core #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [2:0]         op,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] y,
    output logic               cout,
    output logic               sign,
    output logic               err
);

    // Opcode encodings
    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_CMP = 3'b010;
    localparam logic [2:0] c_OP_AND = 3'b011;
    localparam logic [2:0] c_OP_OR  = 3'b100;
    localparam logic [2:0] c_OP_XOR = 3'b101;
    localparam logic [2:0] c_OP_MUL = 3'b110;

    // State encodings
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_BUSY = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // Last multiply iteration: one iteration per bit of b
    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(WIDTH - 1);

    // Reject unsupported widths at elaboration
    generate
        if (WIDTH < 2 || WIDTH > 32) begin : g_bad_width
            $error("alu_seq_core: WIDTH must be in 2..32");
        end
    endgenerate

    logic [1:0]         r_state;
    logic               r_out_valid;
    logic [2*WIDTH-1:0] r_y;
    logic               r_cout;
    logic               r_sign;
    logic               r_err;
    logic [CNT_W-1:0]   r_cnt;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_a_shift;
    logic [WIDTH-1:0]   r_b_shift;

    logic               w_accept;
    logic [WIDTH:0]     w_sum;
    logic               w_lt;
    logic               w_eq;
    logic               w_gt;
    logic [WIDTH-1:0]   w_diff;
    logic [2*WIDTH-1:0] w_res_y;
    logic               w_res_cout;
    logic               w_res_sign;
    logic               w_res_err;
    logic [2*WIDTH-1:0] w_acc_next;

    // Ready while idle, or while the held result is being consumed this cycle
    assign in_ready = !rst && ((r_state == S_IDLE) || ((r_state == S_DONE) && out_ready));
    assign w_accept = in_valid && in_ready;

    assign out_valid = r_out_valid;
    assign y         = r_y;
    assign cout      = r_cout;
    assign sign      = r_sign;
    assign err       = r_err;

    // Shared arithmetic for the single-cycle operations
    assign w_sum  = {1'b0, a} + {1'b0, b};
    assign w_lt   = (a < b);
    assign w_eq   = (a == b);
    assign w_gt   = (a > b);
    assign w_diff = w_lt ? (b - a) : (a - b);

    // Next accumulator value: add the shifted multiplicand when the current multiplier bit is set
    assign w_acc_next = r_acc + (r_b_shift[0] ? r_a_shift : '0);

    // Single-cycle result selection; illegal opcode yields zero with err set
    always_comb begin
        w_res_y    = '0;
        w_res_cout = 1'b0;
        w_res_sign = 1'b0;
        w_res_err  = 1'b0;
        case (op)
            c_OP_ADD: begin
                w_res_y    = {{WIDTH{1'b0}}, w_sum[WIDTH-1:0]};
                w_res_cout = w_sum[WIDTH];
            end
            c_OP_SUB: begin
                w_res_y    = {{WIDTH{1'b0}}, w_diff};
                w_res_sign = w_lt;
            end
            c_OP_CMP: w_res_y = {{(2*WIDTH-3){1'b0}}, w_gt, w_eq, w_lt};
            c_OP_AND: w_res_y = {{WIDTH{1'b0}}, a & b};
            c_OP_OR:  w_res_y = {{WIDTH{1'b0}}, a | b};
            c_OP_XOR: w_res_y = {{WIDTH{1'b0}}, a ^ b};
            c_OP_MUL: w_res_y = '0;
            default:  w_res_err = 1'b1;
        endcase
    end

    // Control FSM, multiplier datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_out_valid <= 1'b0;
            r_y         <= '0;
            r_cout      <= 1'b0;
            r_sign      <= 1'b0;
            r_err       <= 1'b0;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_a_shift   <= '0;
            r_b_shift   <= '0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (w_accept) begin
                        if (op == c_OP_MUL) begin
                            // Latch operands; outputs keep their last values until the product lands
                            r_state     <= S_BUSY;
                            r_out_valid <= 1'b0;
                            r_a_shift   <= {{WIDTH{1'b0}}, a};
                            r_b_shift   <= b;
                            r_acc       <= '0;
                            r_cnt       <= '0;
                        end else begin
                            r_state     <= S_DONE;
                            r_out_valid <= 1'b1;
                            r_y         <= w_res_y;
                            r_cout      <= w_res_cout;
                            r_sign      <= w_res_sign;
                            r_err       <= w_res_err;
                        end
                    end else if ((r_state == S_DONE) && out_ready) begin
                        r_state     <= S_IDLE;
                        r_out_valid <= 1'b0;
                    end
                end
                S_BUSY: begin
                    r_acc     <= w_acc_next;
                    r_a_shift <= r_a_shift << 1;
                    r_b_shift <= r_b_shift >> 1;
                    r_cnt     <= r_cnt + 1'b1;
                    if (r_cnt == c_CNT_LAST) begin
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
                        r_y         <= w_acc_next;
                        r_cout      <= 1'b0;
                        r_sign      <= 1'b0;
                        r_err       <= 1'b0;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_core.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_seq_core
// Description : Directed self-checking bench for alu_seq_core (WIDTH=4 and a
//               WIDTH=8 instance for the wide multiply case).
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_alu_seq_core;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] op;
    logic [3:0] a;
    logic [3:0] b;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] y;
    logic       cout;
    logic       sign;
    logic       err;

    logic        in_valid8;
    logic        in_ready8;
    logic [2:0]  op8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        out_valid8;
    logic        out_ready8;
    logic [15:0] y8;
    logic        cout8;
    logic        sign8;
    logic        err8;

    int tests = 0;
    int fails = 0;

    alu_seq_core #(.WIDTH(4)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
        .y(y), .cout(cout), .sign(sign), .err(err)
    );

    alu_seq_core #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .in_valid(in_valid8), .in_ready(in_ready8),
        .op(op8), .a(a8), .b(b8), .out_valid(out_valid8), .out_ready(out_ready8),
        .y(y8), .cout(cout8), .sign(sign8), .err(err8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present one op to the 4-bit core for exactly one edge, then drop in_valid
    task automatic do_op(input logic [2:0] o, input logic [3:0] xa, input logic [3:0] xb);
        op = o; a = xa; b = xb; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk); #1;
    endtask

    // Full result check for the 4-bit core
    task automatic chk_res(input string tag, input logic [7:0] ey, input logic ec,
                           input logic es, input logic ee);
        chk({tag, "_valid"}, out_valid, 1'b1);
        chk({tag, "_y"},     y, ey);
        chk({tag, "_cout"},  cout, ec);
        chk({tag, "_sign"},  sign, es);
        chk({tag, "_err"},   err, ee);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; op = 3'd0; a = 4'd0; b = 4'd0; out_ready = 1'b1;
        in_valid8 = 1'b0; op8 = 3'd0; a8 = 8'd0; b8 = 8'd0; out_ready8 = 1'b1;
        #2;
        chk("rst_in_ready", in_ready, 1'b0);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_y", y, 8'h00);
        chk("rst_flags", {cout, sign, err}, 3'b000);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", in_ready, 1'b1);

        // Single-cycle ops, back-to-back with out_ready held high
        do_op(3'b000, 4'd9, 4'd8);  chk_res("add_9_8", 8'h01, 1'b1, 1'b0, 1'b0);
        chk("done_in_ready", in_ready, 1'b1);
        do_op(3'b001, 4'd3, 4'd7);  chk_res("sub_3_7", 8'h04, 1'b0, 1'b1, 1'b0);
        do_op(3'b001, 4'd5, 4'd5);  chk_res("sub_5_5", 8'h00, 1'b0, 1'b0, 1'b0);
        do_op(3'b010, 4'd5, 4'd5);  chk_res("cmp_5_5", 8'h02, 1'b0, 1'b0, 1'b0);
        do_op(3'b010, 4'd6, 4'd2);  chk_res("cmp_6_2", 8'h04, 1'b0, 1'b0, 1'b0);
        do_op(3'b011, 4'hC, 4'hA);  chk_res("and_c_a", 8'h08, 1'b0, 1'b0, 1'b0);
        do_op(3'b100, 4'hC, 4'hA);  chk_res("or_c_a",  8'h0E, 1'b0, 1'b0, 1'b0);
        do_op(3'b101, 4'hC, 4'hA);  chk_res("xor_c_a", 8'h06, 1'b0, 1'b0, 1'b0);
        do_op(3'b111, 4'hC, 4'hA);  chk_res("illegal", 8'h00, 1'b0, 1'b0, 1'b1);
        tick();
        chk("drain_out_valid", out_valid, 1'b0);

        // 4-bit multiply: result lands WIDTH edges after accept
        do_op(3'b110, 4'd15, 4'd15);
        chk("mul_busy_in_ready", in_ready, 1'b0);
        chk("mul_busy_valid_0", out_valid, 1'b0);
        a = 4'd1; b = 4'd1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            chk("mul_busy_valid", out_valid, 1'b0);
        end
        tick();
        chk_res("mul_15_15", 8'hE1, 1'b0, 1'b0, 1'b0);

        // 8-bit multiply on the wide instance
        op8 = 3'b110; a8 = 8'd255; b8 = 8'd255; in_valid8 = 1'b1;
        tick();
        in_valid8 = 1'b0;
        chk("mul8_in_ready", in_ready8, 1'b0);
        for (int i = 1; i <= 7; i++) begin
            tick();
            chk("mul8_busy_valid", out_valid8, 1'b0);
        end
        tick();
        chk("mul8_valid", out_valid8, 1'b1);
        chk("mul8_y", y8, 16'hFE01);
        chk("mul8_flags", {cout8, sign8, err8}, 3'b000);
        chk("dut4_idle_after_mul", out_valid, 1'b0);

        // Backpressure: held ADD result, pending SUB ignored until released
        out_ready = 1'b0;
        do_op(3'b000, 4'd7, 4'd3);
        chk_res("bp_add", 8'h0A, 1'b0, 1'b0, 1'b0);
        op = 3'b001; a = 4'd9; b = 4'd2; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_in_ready", in_ready, 1'b0);
            tick();
            chk_res("bp_hold", 8'h0A, 1'b0, 1'b0, 1'b0);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", in_ready, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk_res("bp_pending_sub", 8'h07, 1'b0, 1'b0, 1'b0);
        tick();
        chk("bp_drain_valid", out_valid, 1'b0);

        // Reset during multiply BUSY discards the op immediately
        do_op(3'b110, 4'd15, 4'd15);
        tick();
        rst = 1'b1;
        #1;
        chk("rst_busy_valid", out_valid, 1'b0);
        chk("rst_busy_y", y, 8'h00);
        chk("rst_busy_flags", {cout, sign, err}, 3'b000);
        chk("rst_busy_in_ready", in_ready, 1'b0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("rst_rel_in_ready", in_ready, 1'b1);
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("rst_no_stale_valid", out_valid, 1'b0);
        end
        do_op(3'b000, 4'd2, 4'd3);
        chk_res("post_rst_add", 8'h05, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_seq_core.md
# alu_seq_core

Parametrised, registered ALU core: the sequential successor to the 4-bit select-decoded ALU. It accepts one operation per valid/ready handshake and decodes a 3-bit opcode internally. Supported operations are add, subtract, compare, AND, OR, XOR and a multi-cycle shift-add multiply. The result, carry, sign and error flags are held in output registers until the consumer accepts them. It sits between the operand/opcode source (register file or test sequencer) and the result sink.

## Interface
- WIDTH, 4, operand width in bits; legal range 2..32.
- CNT_W, $clog2(WIDTH)+1, multiply iteration counter width; derived, do not override.

- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operands and opcode present.
- in_ready  output  1  core can accept an operation.
- op  input  3  opcode, sampled on accept.
- a  input  WIDTH  operand A, unsigned, sampled on accept.
- b  input  WIDTH  operand B, unsigned, sampled on accept.
- out_valid  output  1  result registers valid.
- out_ready  input  1  sink accepts result.
- y  output  2*WIDTH  result; upper WIDTH bits are zero except for MUL.
- cout  output  1  ADD carry-out; 0 for other ops.
- sign  output  1  SUB borrow (a<b); 0 for other ops.
- err  output  1  illegal opcode flag.

## Operation
- Opcodes:
  - 000 ADD: y = a+b (low WIDTH bits); cout = carry out of bit WIDTH-1.
  - 001 SUB: y = |a−b| as magnitude; sign = 1 iff a<b; a==b gives y=0, sign=0.
  - 010 CMP: y[2:0] = {a>b, a==b, a<b}; all other bits 0.
  - 011 AND, 100 OR, 101 XOR: bitwise, zero-extended.
  - 110 MUL: unsigned product, full 2*WIDTH bits.
  - 111: illegal; y=0, err=1, all other flags 0.
- State machine:
  - IDLE → DONE on accept of a non-MUL op; result registered in the same edge.
  - IDLE → BUSY on accept of MUL; a, b and the 0 accumulator are latched; counter = 0.
  - BUSY: each cycle, if b_shift[0] then acc += a_shift << 0 (shift-add). a_shift shifts left, b_shift shifts right, counter increments. When counter reaches WIDTH-1, move to DONE with y = final acc.
  - DONE: out_valid=1. On out_ready: go to IDLE if no new accept; if in_valid is also high, accept the new op in the same edge (back-to-back, see in_ready).
- in_ready = !rst && (state==IDLE || (state==DONE && out_ready)).
- Outputs y/cout/sign/err change only on entry to DONE, and hold stable while out_valid && !out_ready.
- Inputs are ignored when in_ready=0. Operand changes after accept do not affect an in-flight op.

## Timing
- Reset (async, immediate): state=IDLE, out_valid=0, y=0, cout=0, sign=0, err=0, counter=0, accumulator=0. in_ready=0 while rst is high, and 1 in the first cycle after release.
- Non-MUL latency: accept at edge N → out_valid=1 after edge N (one cycle).
- MUL latency: accept at edge N → out_valid=1 after edge N+WIDTH.
- Throughput with out_ready held high:
  - One non-MUL op per cycle.
  - MUL occupies WIDTH+1 cycles, including the DONE cycle, during which the next op can be accepted.
- Backpressure: DONE persists indefinitely while out_ready=0, and in_ready=0 for that time.
- Reset mid-BUSY or mid-DONE: the in-flight op is discarded and no out_valid is produced. After release the core behaves as fresh from reset.
- Width rules:
  - All arithmetic is unsigned.
  - ADD wraps modulo 2^WIDTH, with the carry reported on cout.
  - MUL never overflows 2*WIDTH.

## Test plan
- WIDTH=4, ADD a=9 b=8, out_ready=1 → out_valid one cycle after accept; y=0x01, cout=1, sign=0, err=0.
- SUB a=3 b=7 → y=4, sign=1. SUB a=5 b=5 → y=0, sign=0. CMP a=5 b=5 → y=0b010. CMP a=6 b=2 → y=0b100.
- MUL a=15 b=15 → y=225 (0xE1) exactly 4 cycles after accept; in_ready=0 during BUSY. Repeat with WIDTH=8, a=255 b=255 → y=65025 after 8 cycles.
- Back-to-back stream with out_ready=1: AND 0xC & 0xA, OR, XOR, op=111 on consecutive cycles → one result per cycle: 0x8, 0xE, 0x6, then y=0 with err=1.
- Backpressure: ADD result with out_ready=0 for 5 cycles → y/flags stable, in_ready=0, new in_valid ignored. out_ready=1 then releases the result and accepts the pending op in the same edge.
- Assert rst for 1 cycle during MUL BUSY (cycle 2 of 4) → out_valid=0, all outputs 0 immediately. The next ADD after release completes normally.
